left_rotate_pipe: RTL and testbench

//  Pipelined left shifter/rotator, the left-direction counterpart to the 32-bit right barrel shifter.

---
 rtl/left_rotate_pipe.sv | 106 ++++++++++
 tb/tb_left_rotate_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/left_rotate_pipe.sv
// Pipelined left shifter/rotator with valid/ready flow control.
// One binary shift stage per register, largest amount first, then a registered output stage.
module left_rotate_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic             in_rot,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    logic             vld_q   [SHW];
    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   shamt_q [SHW];
    logic             rot_q   [SHW];
    logic [TAG_W-1:0] tag_q   [SHW];
    logic [WIDTH-1:0] shifted [SHW];

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;

    logic adv;
    logic accept;

    function automatic logic [WIDTH-1:0] shl_stage(input logic [WIDTH-1:0] d,
                                                   input int unsigned     n,
                                                   input logic            en,
                                                   input logic            rot);
        logic [WIDTH-1:0] r;
        r = d;
        if (en) begin
            r = d << n;
            if (rot) begin
                r = r | (d >> (WIDTH - n));
            end
        end
        return r;
    endfunction

    // Stage k applies shift amount 2^(SHW-1-k) to its held operand on the way to stage k+1.
    always_comb begin
        adv      = ~out_valid_q | out_ready;
        in_ready = adv & ~flush;
        accept   = in_valid & in_ready;
        for (int k = 0; k < SHW; k++) begin
            shifted[k] = shl_stage(data_q[k], 32'd1 << (SHW - 1 - k),
                                   shamt_q[k][SHW-1-k], rot_q[k]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SHW; k++) begin
                vld_q[k]   <= 1'b0;
                data_q[k]  <= '0;
                shamt_q[k] <= '0;
                rot_q[k]   <= 1'b0;
                tag_q[k]   <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
        end else if (flush) begin
            for (int k = 0; k < SHW; k++) begin
                vld_q[k] <= 1'b0;
            end
            out_valid_q <= 1'b0;
        end else if (adv) begin
            vld_q[0]   <= accept;
            data_q[0]  <= in_data;
            shamt_q[0] <= in_shamt;
            rot_q[0]   <= in_rot;
            tag_q[0]   <= in_tag;
            for (int k = 1; k < SHW; k++) begin
                vld_q[k]   <= vld_q[k-1];
                data_q[k]  <= shifted[k-1];
                shamt_q[k] <= shamt_q[k-1];
                rot_q[k]   <= rot_q[k-1];
                tag_q[k]   <= tag_q[k-1];
            end
            out_valid_q <= vld_q[SHW-1];
            // Bubbles leave the output payload untouched.
            if (vld_q[SHW-1]) begin
                out_data_q <= shifted[SHW-1];
                out_tag_q  <= tag_q[SHW-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_left_rotate_pipe.sv
// Bench for left_rotate_pipe: directed steps plus random traffic checked through a queue scoreboard.
module tb_left_rotate_pipe;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;
    localparam int TAG_W = 4;

    logic             clock;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic             in_rot;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    int checks   = 0;
    int failures = 0;
    int n_acc    = 0;
    int n_out    = 0;
    logic acc_last;
    logic [TAG_W+WIDTH-1:0] sb_q[$];

    left_rotate_pipe #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_rot    (in_rot),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] model(input logic [31:0] x, input int s, input logic r);
        if (s == 0) return x;
        if (r) return (x << s) | (x >> (32 - s));
        return x << s;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] x, input int s, input logic r,
                         input logic [3:0] t);
        in_valid = v;
        in_data  = x;
        in_shamt = s[SHW-1:0];
        in_rot   = r;
        in_tag   = t;
    endtask

    // Called at a falling edge with inputs driven; scores the handshakes of this cycle.
    task automatic tick();
        logic [TAG_W+WIDTH-1:0] exp;
        #1;
        acc_last = in_valid && in_ready;
        if (flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    check("unexpected_output", {out_tag, out_data}, '0);
                end else begin
                    exp = sb_q.pop_front();
                    check("result", {out_tag, out_data}, exp);
                end
            end
            if (acc_last) begin
                sb_q.push_back({in_tag, model(in_data, int'(in_shamt), in_rot)});
                n_acc++;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic run_single(input string name, input logic [31:0] x, input int s,
                              input logic r, input logic [3:0] t, input logic [31:0] exp);
        int n;
        out_ready = 1'b1;
        drive(1'b1, x, s, r, t);
        tick();
        check({name, "_accept"}, acc_last, 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({name, "_latency"}, n, SHW);
        check({name, "_data"}, out_data, exp);
        check({name, "_tag"}, out_tag, t);
        tick();
    endtask

    initial begin
        int i;
        int cyc;
        int sent;
        int acc0;
        int out0;

        reset_n   = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 0, 1'b0, 4'h0);
        @(negedge clock);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_out_tag", out_tag, 0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_in_ready", in_ready, 1);

        // Directed operands with literal results.
        run_single("rot1_s1",  32'h8000_0001, 1,  1'b1, 4'h1, 32'h0000_0003);
        run_single("shl_s1",   32'h8000_0001, 1,  1'b0, 4'h2, 32'h0000_0002);
        run_single("rot1_s31", 32'h0000_0002, 31, 1'b1, 4'h3, 32'h0000_0001);
        run_single("shl_s31",  32'hFFFF_FFFF, 31, 1'b0, 4'h4, 32'h8000_0000);
        run_single("rot_s0",   32'hDEAD_BEEF, 0,  1'b1, 4'h5, 32'hDEAD_BEEF);
        run_single("shl_s0",   32'hCAFE_F00D, 0,  1'b0, 4'h6, 32'hCAFE_F00D);
        run_single("rot_s16",  32'h1234_5678, 16, 1'b1, 4'h7, 32'h5678_1234);

        // Back-to-back stream of 8 ops with a 3-cycle downstream stall.
        out0 = n_out;
        i    = 0;
        cyc  = 0;
        while ((i < 8 || sb_q.size() != 0) && cyc < 60) begin
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (i < 8) drive(1'b1, 32'h1234_5678 + i * 32'h1111, (i * 4 + 1) % 32, i[0], i[3:0]);
            else in_valid = 1'b0;
            #1;
            if (cyc >= 6 && cyc <= 8) check("stall_in_ready", in_ready, 0);
            tick();
            if (acc_last) i++;
            cyc++;
        end
        check("stream_count", n_out - out0, 8);
        out_ready = 1'b1;
        in_valid  = 1'b0;

        // Random traffic.
        acc0 = n_acc;
        out0 = n_out;
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 31),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 9) < 7);
            tick();
            if (acc_last) sent++;
            cyc++;
        end
        check("rand_sent", sent, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        check("rand_drained", sb_q.size(), 0);
        check("rand_out_count", n_out - out0, n_acc - acc0);

        // Flush with three ops in flight and a new op presented.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'hF0F0_0000 + k, 4, 1'b1, 4'(8 + k));
            tick();
        end
        drive(1'b1, 32'hBADB_AD00, 3, 1'b0, 4'hB);
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        tick();
        check("flush_not_accepted", acc_last, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("flush_no_stale", out_valid, 0);
            tick();
        end
        run_single("post_flush", 32'h0000_00FF, 8, 1'b0, 4'hC, 32'h0000_FF00);

        // Asynchronous reset mid-stream.
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 32'hA5A5_0000 | k, 3, 1'b1, 4'(k + 1));
            tick();
        end
        check("pre_reset_valid", out_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_tag", out_tag, 0);
        sb_q.delete();
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        run_single("post_reset", 32'h0000_0001, 31, 1'b1, 4'hD, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
